dp_controller: RTL and testbench
================================

Name: dp_controller

Overview:
- Multi-cycle control FSM directly upstream of the ARM32 register/shifter/ALU datapath.
- Accepts one 32-bit ARM data-processing instruction per handshake and decodes its fields.
- Evaluates the condition code against the datapath status register, then sequences the datapath: operand load, execute, writeback.
- Drives every datapath control input, one state per datapath cycle.

Parameters:
- COND_EN, 1, 1 = evaluate cond[31:28]; 0 = treat every instruction as AL.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction word
- instr_valid  in  1  instr present
- instr_ready  out  1  controller can accept an instruction
- status_in  in  32  datapath status_out; [31:28] = N,Z,C,V
- done  out  1  one-cycle pulse: instruction retired
- skipped  out  1  qualifies done: condition failed, no state changed
- illegal  out  1  qualifies done: unsupported encoding, no state changed
- wb_sel  out  1  tied 0 (writeback from C)
- w_addr, A_addr, B_addr, shift_addr  out  4 each  register addresses
- w_en, en_A, en_B, en_S, en_C, en_status  out  1 each  datapath enables
- shift_op  out  2  shift type
- shift_imme  out  32  shift amount, zero-extended
- sel_shift, sel_A, sel_B  out  1 each  datapath mux selects
- imme_data  out  32  rotated immediate
- ALU_op  out  3  ALU operation

Behaviour:
- Reset:
  - state = IDLE; instruction register = 0.
  - All enables, done, skipped, illegal, wb_sel, sel_* = 0; ALU_op = 0.
  - instr_ready = 1.
- States:
  - IDLE: instr_ready = 1. On instr_valid, latch instr, go to LOAD. Handshake completes when valid and ready are both high.
  - LOAD: instr_ready = 0. Evaluate cond and legality.
    - Fail or illegal: all enables 0, done = 1, skipped or illegal = 1, go to IDLE.
    - Otherwise: en_A = en_B = en_S = 1, go to EXEC.
  - EXEC: en_C = 1. en_status = S bit, or 1 for CMP/TST. Go to WB.
  - WB: w_en = 1 unless CMP/TST. done = 1. Go to IDLE.
- Latency and throughput:
  - Executed instruction: done 3 cycles after the accept edge.
  - Skipped or illegal: done 1 cycle after the accept edge.
  - Maximum throughput is one instruction per 4 cycles; the IDLE cycle is mandatory.
- Decode fields (latched instr):
  - A_addr = [19:16]; w_addr = [15:12]; B_addr = [3:0]; shift_addr = [11:8].
  - These are combinational from the instruction register and stable from LOAD through WB.
- Operand 2:
  - I = 1: sel_B = 1. imme_data = ROR(zext(imm8[7:0]), 2*rot[11:8]).
  - I = 0: sel_B = 0; shift_op = [6:5].
    - [4] = 0: sel_shift = 0, shift_imme = zext([11:7]).
    - [4] = 1 with [7] = 0: sel_shift = 1.
    - [4] = 1 with [7] = 1: illegal.
- Opcode [24:21] → ALU_op:
  - ADD 0100 → 000; SUB 0010 → 001; CMP 1010 → 001.
  - AND 0000 → 010; TST 1000 → 010.
  - ORR 1100 → 011; EOR 0001 → 100.
  - MOV 1101 → 000 with sel_A = 1.
  - sel_A = 0 for every other opcode.
  - Any other opcode, or [27:26] ≠ 00: illegal.
- Condition codes:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N.
  - 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL true; 1111 treated as illegal.
- Flags are sampled in LOAD. The previous instruction's status write has already completed, so no forwarding is needed.
- Enables are single-cycle pulses; no enable is asserted outside its state.
- instr_valid while not in IDLE is ignored. The upstream source must hold instr until the handshake completes.
- rst_n asserted mid-instruction:
  - Immediate return to IDLE with all outputs at reset values.
  - A partially executed instruction produces no done pulse and no w_en.

Test Plan:
- Reset then idle: rst_n low, clk running → instr_ready = 1, all enables 0, done = 0; rst_n high, instr_valid = 0 for 10 cycles → no enable ever asserts.
- ADD immediate: 0xE2821005 (ADD r1,r2,#5), r2 = 7 → LOAD: A_addr = 2, en_A/B/S; EXEC: sel_B = 1, imme_data = 5, ALU_op = 000, en_status = 0; WB: w_addr = 1, w_en, done; r1 = 12.
- MOV with shift: 0xE1A03104 (MOV r3,r4,LSL #2), r4 = 3 → sel_A = 1, shift_op = 00, shift_imme = 2, sel_shift = 0; r3 = 12.
- Flag path:
  - SUBS 0xE2500001 with r0 = 1 → en_status in EXEC; Z set.
  - Then ADDEQ 0x02811001 → executes, r1 increments.
  - Then CMP 0xE3510000 with r1 ≠ 0 → en_status = 1, w_en never asserts.
  - Then ADDEQ again → done + skipped one cycle after accept, no enables.
- Illegal: 0xE0C00000 (SBC) and 0xE5912000 (LDR) → done + illegal one cycle after accept; w_en, en_C, en_status stay 0.
- Reset mid-instruction: drop rst_n during EXEC of 0xE2821005 → outputs immediately at reset values, no done pulse, no w_en; the next instruction after release executes normally.

Source files
------------

// File: rtl/dp_controller.sv
// rtl/dp_controller.sv - multi-cycle control FSM for ARM data-processing instructions
module dp_controller #(
  parameter bit COND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] status_in,
  output logic        done,
  output logic        skipped,
  output logic        illegal,
  output logic        wb_sel,
  output logic [3:0]  w_addr,
  output logic [3:0]  A_addr,
  output logic [3:0]  B_addr,
  output logic [3:0]  shift_addr,
  output logic        w_en,
  output logic        en_A,
  output logic        en_B,
  output logic        en_S,
  output logic        en_C,
  output logic        en_status,
  output logic [1:0]  shift_op,
  output logic [31:0] shift_imme,
  output logic        sel_shift,
  output logic        sel_A,
  output logic        sel_B,
  output logic [31:0] imme_data,
  output logic [2:0]  ALU_op
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_t;

  state_t      state, state_nx;
  logic [31:0] ir;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        cond_pass;
  logic        op_ok, is_mov, is_cmp_tst;
  logic [2:0]  alu_dec;
  logic        illegal_enc;
  logic        busy;
  logic [31:0] imm8;
  logic [4:0]  rot_amt;
  logic        unused_bits;

  // With condition evaluation disabled every instruction behaves as AL.
  assign cond    = COND_EN ? ir[31:28] : 4'hE;
  assign opcode  = ir[24:21];
  assign {flag_n, flag_z, flag_c, flag_v} = status_in[31:28];
  assign unused_bits = ^{status_in[27:0], ir[31:28]};
  assign busy    = (state != IDLE);

  // Register fields come straight from the latched word, stable LOAD..WB.
  assign A_addr     = ir[19:16];
  assign w_addr     = ir[15:12];
  assign shift_addr = ir[11:8];
  assign B_addr     = ir[3:0];
  assign shift_op   = ir[6:5];
  assign shift_imme = {27'h0, ir[11:7]};
  assign wb_sel     = 1'b0;

  // Rotated immediate: imm8 rotated right by twice the 4-bit rotate field.
  assign imm8      = {24'h0, ir[7:0]};
  assign rot_amt   = {ir[11:8], 1'b0};
  assign imme_data = (imm8 >> rot_amt) | (imm8 << (6'd32 - {1'b0, rot_amt}));

  // Selects and ALU op are held at reset values while idle.
  assign sel_B     = busy & ir[25];
  assign sel_shift = busy & ~ir[25] & ir[4];
  assign sel_A     = busy & is_mov;
  assign ALU_op    = busy ? alu_dec : 3'b000;

  // Operand-2 register-shift with bit 7 set is not a data-processing encoding.
  assign illegal_enc = (ir[27:26] != 2'b00) || !op_ok ||
                       (!ir[25] && ir[4] && ir[7]) || (cond == 4'hF);

  // State register and instruction latch; the word is captured on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == IDLE && instr_valid) ir <= instr;
    end
  end

  // Condition-code evaluation against the sampled NZCV flags.
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Opcode to ALU operation; anything unlisted is flagged illegal.
  always_comb begin
    op_ok      = 1'b1;
    is_mov     = 1'b0;
    is_cmp_tst = 1'b0;
    alu_dec    = 3'b000;
    case (opcode)
      4'b0100: alu_dec = 3'b000;
      4'b0010: alu_dec = 3'b001;
      4'b1010: begin alu_dec = 3'b001; is_cmp_tst = 1'b1; end
      4'b0000: alu_dec = 3'b010;
      4'b1000: begin alu_dec = 3'b010; is_cmp_tst = 1'b1; end
      4'b1100: alu_dec = 3'b011;
      4'b0001: alu_dec = 3'b100;
      4'b1101: begin alu_dec = 3'b000; is_mov = 1'b1; end
      default: op_ok = 1'b0;
    endcase
  end

  // Next-state and per-state datapath enables; each enable lives in one state.
  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    skipped     = 1'b0;
    illegal     = 1'b0;
    en_A        = 1'b0;
    en_B        = 1'b0;
    en_S        = 1'b0;
    en_C        = 1'b0;
    en_status   = 1'b0;
    w_en        = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = LOAD;
      end
      LOAD: begin
        if (illegal_enc) begin
          done     = 1'b1;
          illegal  = 1'b1;
          state_nx = IDLE;
        end else if (!cond_pass) begin
          done     = 1'b1;
          skipped  = 1'b1;
          state_nx = IDLE;
        end else begin
          en_A     = 1'b1;
          en_B     = 1'b1;
          en_S     = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        en_C      = 1'b1;
        en_status = ir[20] | is_cmp_tst;
        state_nx  = WB;
      end
      WB: begin
        w_en     = !is_cmp_tst;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dp_controller.sv
// tb/tb_dp_controller.sv - self-checking bench for dp_controller with a modelled datapath
module tb_dp_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] status_in;
  logic        done, skipped, illegal, wb_sel;
  logic [3:0]  w_addr, A_addr, B_addr, shift_addr;
  logic        w_en, en_A, en_B, en_S, en_C, en_status;
  logic [1:0]  shift_op;
  logic [31:0] shift_imme;
  logic        sel_shift, sel_A, sel_B;
  logic [31:0] imme_data;
  logic [2:0]  ALU_op;

  int vectors = 0;
  int miscompares = 0;

  // Downstream datapath stand-in, driven only by the controller's outputs
  logic [31:0] rf [16];
  logic [3:0]  nzcv;
  logic [27:0] junk = '0;
  logic [31:0] a_q, b_q, s_q, c_q;
  logic [31:0] k_dp, op2_dp, opa_dp, res_dp;
  logic [32:0] sum_dp;
  logic [3:0]  nzcv_nx;
  logic        set_en = 1'b0;
  logic [3:0]  set_addr = '0;
  logic [31:0] set_val = '0;
  logic        setf_en = 1'b0;
  logic [3:0]  setf_val = '0;

  // Architectural reference state
  logic [31:0] mregs [16];
  logic [3:0]  mflags;

  dp_controller dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .status_in(status_in), .done(done),
    .skipped(skipped), .illegal(illegal), .wb_sel(wb_sel), .w_addr(w_addr),
    .A_addr(A_addr), .B_addr(B_addr), .shift_addr(shift_addr), .w_en(w_en),
    .en_A(en_A), .en_B(en_B), .en_S(en_S), .en_C(en_C), .en_status(en_status),
    .shift_op(shift_op), .shift_imme(shift_imme), .sel_shift(sel_shift),
    .sel_A(sel_A), .sel_B(sel_B), .imme_data(imme_data), .ALU_op(ALU_op)
  );

  always #5 clk = ~clk;

  assign status_in = {nzcv, junk};
  always @(negedge clk) junk <= 28'($urandom);

  function automatic logic [31:0] shift_val(input logic [31:0] b, input logic [1:0] t,
                                            input logic [31:0] k);
    logic [31:0] r;
    r = {27'h0, k[4:0]};
    case (t)
      2'd0: shift_val = (k >= 32) ? 32'h0 : (b << k);
      2'd1: shift_val = (k >= 32) ? 32'h0 : (b >> k);
      2'd2: shift_val = (k >= 32) ? {32{b[31]}} : 32'($signed(b) >>> k);
      default: shift_val = (r == 0) ? b : ((b >> r) | (b << (32'd32 - r)));
    endcase
  endfunction

  always_comb begin
    k_dp   = sel_shift ? {24'h0, s_q[7:0]} : shift_imme;
    op2_dp = sel_B ? imme_data : shift_val(b_q, shift_op, k_dp);
    opa_dp = sel_A ? 32'h0 : a_q;
    sum_dp = {1'b0, opa_dp} + {1'b0, op2_dp};
    case (ALU_op)
      3'd0: res_dp = sum_dp[31:0];
      3'd1: res_dp = opa_dp - op2_dp;
      3'd2: res_dp = opa_dp & op2_dp;
      3'd3: res_dp = opa_dp | op2_dp;
      3'd4: res_dp = opa_dp ^ op2_dp;
      default: res_dp = 32'h0;
    endcase
    nzcv_nx = {res_dp[31], res_dp == 32'h0, nzcv[1:0]};
    if (!sel_A && ALU_op == 3'd0)
      nzcv_nx[1:0] = {sum_dp[32], (opa_dp[31] == op2_dp[31]) && (res_dp[31] != opa_dp[31])};
    else if (!sel_A && ALU_op == 3'd1)
      nzcv_nx[1:0] = {opa_dp >= op2_dp, (opa_dp[31] != op2_dp[31]) && (res_dp[31] != opa_dp[31])};
  end

  always @(posedge clk) begin
    if (set_en) rf[set_addr] <= set_val;
    if (setf_en) nzcv <= setf_val;
    if (en_A) a_q <= rf[A_addr];
    if (en_B) b_q <= rf[B_addr];
    if (en_S) s_q <= rf[shift_addr];
    if (en_C) c_q <= res_dp;
    if (en_status) nzcv <= nzcv_nx;
    if (w_en) rf[w_addr] <= c_q;
  end

  task automatic set_reg(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk); set_en = 1'b1; set_addr = a; set_val = v;
    @(negedge clk); set_en = 1'b0;
    mregs[a] = v;
  endtask

  task automatic set_flags(input logic [3:0] f);
    @(negedge clk); setf_en = 1'b1; setf_val = f;
    @(negedge clk); setf_en = 1'b0;
    mflags = f;
  endtask

  // Architectural semantics: kind 0 executed, 1 condition failed, 2 illegal
  task automatic model_step(input logic [31:0] ins, output int kind, output logic wr,
                            output logic stat);
    logic [3:0] op;
    logic n, z, c, v, pass, arith;
    logic [31:0] a, op2, res, k;
    logic [32:0] sum;
    op = ins[24:21];
    {n, z, c, v} = mflags;
    case (ins[31:28])
      4'h0: pass = z;          4'h1: pass = !z;
      4'h2: pass = c;          4'h3: pass = !c;
      4'h4: pass = n;          4'h5: pass = !n;
      4'h6: pass = v;          4'h7: pass = !v;
      4'h8: pass = c && !z;    4'h9: pass = !c || z;
      4'hA: pass = n == v;     4'hB: pass = n != v;
      4'hC: pass = !z && n == v;
      4'hD: pass = z || n != v;
      default: pass = 1'b1;
    endcase
    wr = 1'b0; stat = 1'b0;
    if (ins[27:26] != 2'b00 ||
        !(op inside {4'h4, 4'h2, 4'hA, 4'h0, 4'h8, 4'hC, 4'h1, 4'hD}) ||
        (!ins[25] && ins[4] && ins[7]) || ins[31:28] == 4'hF) begin
      kind = 2;
    end else if (!pass) begin
      kind = 1;
    end else begin
      kind = 0;
      if (ins[25]) begin
        op2 = shift_val({24'h0, ins[7:0]}, 2'b11, {27'h0, ins[11:8], 1'b0});
      end else begin
        k = ins[4] ? {24'h0, mregs[ins[11:8]][7:0]} : {27'h0, ins[11:7]};
        op2 = shift_val(mregs[ins[3:0]], ins[6:5], k);
      end
      a = mregs[ins[19:16]];
      arith = 1'b0;
      case (op)
        4'h4: begin
          sum = {1'b0, a} + {1'b0, op2}; res = sum[31:0]; c = sum[32];
          v = (a[31] == op2[31]) && (res[31] != a[31]); arith = 1'b1;
        end
        4'h2, 4'hA: begin
          res = a - op2; c = (a >= op2);
          v = (a[31] != op2[31]) && (res[31] != a[31]); arith = 1'b1;
        end
        4'h0, 4'h8: res = a & op2;
        4'hC:       res = a | op2;
        4'h1:       res = a ^ op2;
        default:    res = op2;
      endcase
      wr = !(op == 4'hA || op == 4'h8);
      stat = ins[20] || !wr;
      if (stat) mflags = {res[31], res == 32'h0, arith ? c : mflags[1], arith ? v : mflags[0]};
      if (wr) mregs[ins[15:12]] = res;
    end
  endtask

  // Hand one instruction over and observe the controller until it retires
  task automatic issue(input logic [31:0] ins, output int done_at, output logic sk,
                       output logic il, output logic saw_wen, output logic saw_stat,
                       output logic saw_any);
    int t;
    done_at = 0; sk = 0; il = 0; saw_wen = 0; saw_stat = 0; saw_any = 0; t = 0;
    @(negedge clk);
    while (!instr_ready && t < 20) begin @(negedge clk); t++; end
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = $urandom;
    for (int c = 1; c <= 6 && done_at == 0; c++) begin
      @(negedge clk);
      saw_wen  |= w_en;
      saw_stat |= en_status;
      saw_any  |= en_A | en_B | en_S | en_C | en_status | w_en;
      if (done) begin done_at = c; sk = skipped; il = illegal; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    logic any_en;
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    vectors++;
    if ({en_A, en_B, en_S, en_C, en_status, w_en, done, skipped, illegal, wb_sel,
         sel_A, sel_B, sel_shift, ALU_op} !== 16'h0) begin
      miscompares++; $display("FAIL reset_outputs got nonzero control outputs exp=0");
    end
    rst_n = 1'b1;
    any_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      any_en |= en_A | en_B | en_S | en_C | en_status | w_en | done;
    end
    vectors++;
    if (any_en !== 1'b0) begin miscompares++; $display("FAIL idle_quiet got=%b exp=0", any_en); end
    set_flags(4'h0);
  endtask

  task automatic test_add_imm;
    set_reg(4'd2, 32'd7);
    @(negedge clk);
    instr = 32'hE2821005; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({A_addr, en_A, en_B, en_S, done, instr_ready} !== {4'd2, 3'b111, 2'b00}) begin
      miscompares++; $display("FAIL add_load got A=%0d en=%b%b%b done=%b rdy=%b exp A=2 en=111 done=0 rdy=0",
                              A_addr, en_A, en_B, en_S, done, instr_ready);
    end
    @(negedge clk);
    vectors++;
    if ({sel_B, imme_data, ALU_op, en_C, en_status} !== {1'b1, 32'd5, 3'b000, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL add_exec got selB=%b imm=%0d op=%0d enC=%b enS=%b exp 1 5 0 1 0",
                              sel_B, imme_data, ALU_op, en_C, en_status);
    end
    @(negedge clk);
    vectors++;
    if ({w_addr, w_en, done, skipped, illegal} !== {4'd1, 2'b11, 2'b00}) begin
      miscompares++; $display("FAIL add_wb got w_addr=%0d w_en=%b done=%b sk=%b il=%b exp 1 1 1 0 0",
                              w_addr, w_en, done, skipped, illegal);
    end
    @(posedge clk); #1;
    vectors++;
    if (rf[1] !== 32'd12) begin miscompares++; $display("FAIL add_result got=%0d exp=12", rf[1]); end
  endtask

  task automatic test_mov_shift;
    set_reg(4'd4, 32'd3);
    @(negedge clk);
    instr = 32'hE1A03104; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({sel_A, shift_op, shift_imme, sel_shift, sel_B} !== {1'b1, 2'b00, 32'd2, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL mov_exec got selA=%b sop=%0d simm=%0d sels=%b selB=%b exp 1 0 2 0 0",
                              sel_A, shift_op, shift_imme, sel_shift, sel_B);
    end
    @(negedge clk);
    @(posedge clk); #1;
    vectors++;
    if (rf[3] !== 32'd12) begin miscompares++; $display("FAIL mov_result got=%0d exp=12", rf[3]); end
  endtask

  task automatic test_flag_path;
    int d; logic sk, il, wn, st, an;
    set_reg(4'd0, 32'd1);
    issue(32'hE2500001, d, sk, il, wn, st, an);
    vectors++;
    if ({d, st, nzcv[2]} !== {32'd3, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL subs got done_at=%0d en_status=%b Z=%b exp 3 1 1", d, st, nzcv[2]);
    end
    issue(32'h02811001, d, sk, il, wn, st, an);
    vectors++;
    if ({d, sk, rf[1]} !== {32'd3, 1'b0, 32'd13}) begin
      miscompares++; $display("FAIL addeq_taken got done_at=%0d sk=%b r1=%0d exp 3 0 13", d, sk, rf[1]);
    end
    issue(32'hE3510000, d, sk, il, wn, st, an);
    vectors++;
    if ({d, st, wn, nzcv[2]} !== {32'd3, 1'b1, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL cmp got done_at=%0d en_status=%b w_en=%b Z=%b exp 3 1 0 0", d, st, wn, nzcv[2]);
    end
    issue(32'h02811001, d, sk, il, wn, st, an);
    vectors++;
    if ({d, sk, il, an, rf[1]} !== {32'd1, 1'b1, 1'b0, 1'b0, 32'd13}) begin
      miscompares++; $display("FAIL addeq_skip got done_at=%0d sk=%b il=%b any_en=%b r1=%0d exp 1 1 0 0 13",
                              d, sk, il, an, rf[1]);
    end
  endtask

  task automatic test_illegal;
    int d; logic sk, il, wn, st, an;
    logic [31:0] bad [2];
    bad[0] = 32'hE0C00000;
    bad[1] = 32'hE5912000;
    for (int i = 0; i < 2; i++) begin
      issue(bad[i], d, sk, il, wn, st, an);
      vectors++;
      if ({d, sk, il, an} !== {32'd1, 1'b0, 1'b1, 1'b0}) begin
        miscompares++; $display("FAIL illegal_%0h got done_at=%0d sk=%b il=%b any_en=%b exp 1 0 1 0",
                                bad[i], d, sk, il, an);
      end
    end
  endtask

  task automatic test_reset_mid;
    int d; logic sk, il, wn, st, an, leak;
    @(negedge clk);
    instr = 32'hE2821005; instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (en_C !== 1'b1) begin miscompares++; $display("FAIL mid_exec_reached got en_C=%b exp=1", en_C); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({instr_ready, en_A, en_B, en_S, en_C, en_status, w_en, done, sel_A, sel_B, sel_shift, ALU_op}
        !== {1'b1, 13'h0}) begin
      miscompares++; $display("FAIL mid_reset_outputs got rdy=%b enC=%b w_en=%b done=%b selB=%b op=%0d exp rdy=1 rest 0",
                              instr_ready, en_C, w_en, done, sel_B, ALU_op);
    end
    leak = 1'b0;
    repeat (2) begin @(negedge clk); leak |= done | w_en; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({leak, rf[1]} !== {1'b0, 32'd13}) begin
      miscompares++; $display("FAIL mid_reset_no_retire got leak=%b r1=%0d exp 0 13", leak, rf[1]);
    end
    issue(32'hE2821005, d, sk, il, wn, st, an);
    vectors++;
    if ({d, wn, rf[1]} !== {32'd3, 1'b1, 32'd12}) begin
      miscompares++; $display("FAIL after_reset got done_at=%0d w_en=%b r1=%0d exp 3 1 12", d, wn, rf[1]);
    end
  endtask

  task automatic test_back_to_back;
    int acc[$];
    int cyc, i;
    logic ready_s;
    set_reg(4'd5, 32'd100);
    cyc = 0; i = 0;
    while (i < 3 && cyc < 40) begin
      @(negedge clk);
      ready_s = instr_ready;
      instr = 32'hE2855001; instr_valid = 1'b1;
      @(posedge clk);
      if (ready_s) begin acc.push_back(cyc); i++; end
      cyc++;
    end
    #1 instr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (acc.size() != 3) begin
      miscompares++; $display("FAIL b2b_accepts got=%0d exp=3", acc.size());
    end else begin
      vectors++;
      if (acc[1] - acc[0] != 4 || acc[2] - acc[1] != 4) begin
        miscompares++; $display("FAIL b2b_spacing got=%0d,%0d exp=4,4", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    vectors++;
    if (rf[5] !== 32'd103) begin miscompares++; $display("FAIL b2b_result got=%0d exp=103", rf[5]); end
  endtask

  task automatic test_random;
    int d, kind, exp_d;
    logic sk, il, wn, st, an, wr, stat;
    logic [3:0] ops [8];
    logic [31:0] ins;
    logic [3:0] cond, op;
    logic [11:0] low;
    logic i_bit;
    ops[0] = 4'h4; ops[1] = 4'h2; ops[2] = 4'hA; ops[3] = 4'h0;
    ops[4] = 4'h8; ops[5] = 4'hC; ops[6] = 4'h1; ops[7] = 4'hD;
    for (int r = 0; r < 16; r++) set_reg(4'(r), $urandom);
    set_flags(4'($urandom));
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) set_flags(4'($urandom));
      cond  = ($urandom_range(0, 19) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      op    = ($urandom_range(0, 11) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
      i_bit = 1'($urandom);
      low   = 12'($urandom);
      if (!i_bit && low[4] && $urandom_range(0, 3) != 0) low[7] = 1'b0;
      ins = {cond, ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00, i_bit, op,
             1'($urandom), 4'($urandom), 4'($urandom), low};
      model_step(ins, kind, wr, stat);
      issue(ins, d, sk, il, wn, st, an);
      exp_d = (kind == 0) ? 3 : 1;
      vectors++;
      if (d != exp_d || sk !== (kind == 1) || il !== (kind == 2)) begin
        miscompares++; $display("FAIL rand_retire ins=%h got done_at=%0d sk=%b il=%b exp %0d %b %b",
                                ins, d, sk, il, exp_d, kind == 1, kind == 2);
      end
      vectors++;
      if (wn !== wr || st !== stat || (kind != 0 && an !== 1'b0)) begin
        miscompares++; $display("FAIL rand_enables ins=%h got w_en=%b en_status=%b any=%b exp %b %b",
                                ins, wn, st, an, wr, stat);
      end
      vectors++;
      if (rf[ins[15:12]] !== mregs[ins[15:12]]) begin
        miscompares++; $display("FAIL rand_result ins=%h got=%h exp=%h", ins, rf[ins[15:12]], mregs[ins[15:12]]);
      end
      vectors++;
      if (nzcv !== mflags) begin
        miscompares++; $display("FAIL rand_flags ins=%h got=%b exp=%b", ins, nzcv, mflags);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_add_imm;
    test_mov_shift;
    test_flag_path;
    test_illegal;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
